// File: rtl/myfilter_dp.sv
// 5-tap FIR datapath: executes one controller command per clock (shift, tap MAC, saturate).
// Latency: every command is registered; its effect is visible the cycle after the edge.
// Backpressure: none; valid_out is a one-cycle pulse and the downstream must accept it.
package myfilter_dp_pkg;
    typedef enum logic [3:0] {
        CMD_NOP    = 4'd0,
        CMD_SHIFT  = 4'd1,
        CMD_TAP0F  = 4'd2,
        CMD_TAP0   = 4'd3,
        CMD_TAP1   = 4'd4,
        CMD_TAP2   = 4'd5,
        CMD_TAP3   = 4'd6,
        CMD_TAP4   = 4'd7,
        CMD_SAT_SH = 4'd8
    } dp_cmd_t;
endpackage

module myfilter_dp
    import myfilter_dp_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int FRAC_BITS   = 15,
    parameter int ACC_WIDTH   = 36
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  dp_cmd_t                cmd_in,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   cload_in,
    input  logic [2:0]             caddr_in,
    input  logic [COEFF_WIDTH-1:0] cdata_in,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    output logic                   sat_out
);

    localparam int PW = DATA_WIDTH + COEFF_WIDTH;

    logic signed [DATA_WIDTH-1:0]  x [5];
    logic signed [COEFF_WIDTH-1:0] c [5];
    logic signed [ACC_WIDTH-1:0]   acc;

    logic [2:0]                    tap_k;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   r;
    logic [ACC_WIDTH-DATA_WIDTH:0] r_hi;
    logic                          pos_ovf;
    logic                          neg_ovf;

    always_comb begin
        tap_k = 3'd0;
        case (cmd_in)
            CMD_TAP1: tap_k = 3'd1;
            CMD_TAP2: tap_k = 3'd2;
            CMD_TAP3: tap_k = 3'd3;
            CMD_TAP4: tap_k = 3'd4;
            default:  tap_k = 3'd0;
        endcase
    end

    // Coefficient reads see the pre-edge value, so a same-cycle write affects only later taps.
    always_comb begin
        prod     = x[tap_k] * c[tap_k];
        prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end

    // Result fits DATA_WIDTH only if all bits from the sign bit down to DATA_WIDTH-1 agree.
    always_comb begin
        r       = acc >>> FRAC_BITS;
        r_hi    = r[ACC_WIDTH-1:DATA_WIDTH-1];
        pos_ovf = !r[ACC_WIDTH-1] && (|r_hi);
        neg_ovf = r[ACC_WIDTH-1] && !(&r_hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                x[k] <= '0;
                c[k] <= '0;
            end
            acc       <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            sat_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;

            for (int k = 0; k < 5; k++) begin
                if (cload_in && (caddr_in == 3'(k))) begin
                    c[k] <= cdata_in;
                end
            end

            case (cmd_in)
                CMD_SHIFT: begin
                    for (int k = 4; k > 0; k--) begin
                        x[k] <= x[k-1];
                    end
                    x[0] <= data_in;
                end
                CMD_TAP0F: acc <= prod_ext;
                CMD_TAP0, CMD_TAP1, CMD_TAP2, CMD_TAP3, CMD_TAP4: acc <= acc + prod_ext;
                CMD_SAT_SH: begin
                    valid_out <= 1'b1;
                    if (pos_ovf) begin
                        data_out <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
                        sat_out  <= 1'b1;
                    end else if (neg_ovf) begin
                        data_out <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
                        sat_out  <= 1'b1;
                    end else begin
                        data_out <= r[DATA_WIDTH-1:0];
                        sat_out  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_myfilter_dp.sv
// Directed bench for myfilter_dp: stimulus pushes expected {sat,data}; a monitor pops on valid_out.
module tb_myfilter_dp;
    import myfilter_dp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    dp_cmd_t     cmd_in = CMD_NOP;
    logic [15:0] data_in = '0;
    logic        cload_in = 1'b0;
    logic [2:0]  caddr_in = '0;
    logic [15:0] cdata_in = '0;
    logic [15:0] data_out;
    logic        valid_out;
    logic        sat_out;

    int npass = 0;
    int ncheck = 0;
    logic [16:0] exp_q [$];
    logic        prev_valid = 1'b0;

    myfilter_dp dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .data_in(data_in),
        .cload_in(cload_in), .caddr_in(caddr_in), .cdata_in(cdata_in),
        .data_out(data_out), .valid_out(valid_out), .sat_out(sat_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncheck++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                chk("valid_pulse_width", 32'(prev_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data_out", 32'(data_out), 32'(e[15:0]));
                    chk("sat_out", 32'(sat_out), 32'(e[16]));
                end
            end
            prev_valid = (valid_out === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input dp_cmd_t c);
        cmd_in = c;
        @(negedge clk);
        cmd_in   = CMD_NOP;
        cload_in = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] v);
        cload_in = 1'b1;
        caddr_in = a;
        cdata_in = v;
        @(negedge clk);
        cload_in = 1'b0;
    endtask

    task automatic shift(input logic [15:0] v);
        data_in = v;
        step(CMD_SHIFT);
    endtask

    task automatic sat(input logic s, input logic [15:0] d);
        exp_q.push_back({s, d});
        step(CMD_SAT_SH);
    endtask

    task automatic taps();
        step(CMD_TAP0F);
        step(CMD_TAP1);
        step(CMD_TAP2);
        step(CMD_TAP3);
        step(CMD_TAP4);
    endtask

    task automatic set_all_c(input logic [15:0] v);
        for (int k = 0; k < 5; k++) wr(3'(k), v);
    endtask

    task automatic mid_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_data_out"}, 32'(data_out), 32'd0);
        chk({tag, "_sat_out"}, 32'(sat_out), 32'd0);
        chk({tag, "_valid_out"}, 32'(valid_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_valid_out", 32'(valid_out), 32'd0);
        chk("reset_sat_out", 32'(sat_out), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sat(1'b0, 16'h0000);

        // Single tap: 0x1000 * 0x4000 >> 15 = 0x0800
        wr(3'd0, 16'h4000);
        shift(16'h1000);
        taps();
        sat(1'b0, 16'h0800);

        // Delay line through tap 4 with truncation
        wr(3'd0, 16'h0000);
        wr(3'd4, 16'h7FFF);
        shift(16'h0100); shift(16'h0200); shift(16'h0300); shift(16'h0400); shift(16'h0500);
        taps();
        sat(1'b0, 16'h00FF);
        shift(16'h0600);
        taps();
        sat(1'b0, 16'h01FF);

        // Positive and negative saturation
        set_all_c(16'h7FFF);
        for (int i = 0; i < 5; i++) shift(16'h7FFF);
        taps();
        sat(1'b1, 16'h7FFF);
        for (int i = 0; i < 5; i++) shift(16'h8000);
        taps();
        sat(1'b1, 16'h8000);

        // NOPs and unlisted encodings hold acc and outputs
        step(CMD_NOP); step(CMD_NOP);
        step(dp_cmd_t'(4'hF)); step(dp_cmd_t'(4'h9));
        chk("hold_data_out", 32'(data_out), 32'h8000);
        chk("hold_sat_out", 32'(sat_out), 32'd1);
        chk("hold_valid_out", 32'(valid_out), 32'd0);
        sat(1'b1, 16'h8000);

        // TAP0F discards the large negative accumulation
        wr(3'd0, 16'h4000);
        shift(16'h0200);
        step(CMD_TAP0F);
        sat(1'b0, 16'h0100);

        for (int i = 0; i < 5; i++) shift(16'h0000);
        taps();
        sat(1'b0, 16'h0000);

        // Writes to addresses 5..7 must not land anywhere
        for (int k = 1; k < 5; k++) wr(3'(k), 16'h0000);
        wr(3'd5, 16'h7FFF); wr(3'd6, 16'h7FFF); wr(3'd7, 16'h7FFF);
        for (int i = 0; i < 5; i++) shift(16'h1000);
        taps();
        sat(1'b0, 16'h0800);

        // Same-cycle write of c[1] during TAP1: old 0x2000 used, new 0x4000 next pass
        wr(3'd1, 16'h2000);
        wr(3'd0, 16'h0000);
        step(CMD_TAP0F);
        cload_in = 1'b1; caddr_in = 3'd1; cdata_in = 16'h4000;
        step(CMD_TAP1);
        step(CMD_TAP2); step(CMD_TAP3); step(CMD_TAP4);
        sat(1'b0, 16'h0400);
        taps();
        sat(1'b0, 16'h0800);

        // Reset between TAP2 and TAP3 clears outputs and partial accumulation
        step(CMD_TAP0F); step(CMD_TAP1); step(CMD_TAP2);
        mid_reset_check("midrst");
        sat(1'b0, 16'h0000);
        // Coefficients were cleared
        for (int i = 0; i < 5; i++) shift(16'h1000);
        taps();
        sat(1'b0, 16'h0000);

        // Delay line was cleared
        wr(3'd2, 16'h4000);
        sat(1'b0, 16'h0000);
        step(CMD_TAP2);
        mid_reset_check("rst2");
        set_all_c(16'h4000);
        taps();
        sat(1'b0, 16'h0000);

        repeat (4) @(negedge clk);
        chk("outputs_outstanding", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end
endmodule
